uart_rx_voter: RTL and testbench
================================

# uart_rx_voter

Noise-tolerant serial receiver for the UART link between two `UART` instances, where each channel passes through a `NOISE_GENERATOR`. It oversamples every bit, takes a majority vote, checks even parity and the stop bit, and presents each frame on a one-entry valid/ready holding register. It sits on the receive side of the channel (`rx_channel_in`) and pairs with an oversampling transmitter that holds each bit for `OVERSAMPLE` clocks.

## Interface
- `BIT_LEN`, default 7, is the number of data bits per frame, sent LSB first.
- `OVERSAMPLE`, default 3, is the number of clocks per bit. It must be odd and at least 3.
- `clk`  in  1  is the single clock. All logic is on the rising edge.
- `rstn`  in  1  is the reset: synchronous, active-low.
- `rx_channel_in`  in  1  is the serial line. It idles high.
- `rx_data_ready`  in  1  is the consumer-accepts signal. It is sampled only while `rx_data_valid` is high.
- `rx_data_out`  out  `BIT_LEN`  is the received data word.
- `rx_data_valid`  out  1  indicates the holding register contains a frame.
- `rx_parity_err`  out  1  is the parity-check result for the held frame.
- `rx_frame_err`  out  1  indicates the held frame's stop bit voted 0.
- `rx_overrun`  out  1  is a one-cycle pulse indicating a completed frame was dropped.

## Operation
- Frame format: 1 start bit (0), `BIT_LEN` data bits (LSB first), 1 even-parity bit, 1 stop bit (1). With the defaults this is 10 bits, or 30 clocks.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- Bit voting:
  - A sample counter runs 0..`OVERSAMPLE`-1 and a ones counter is `$clog2(OVERSAMPLE+1)` bits wide.
  - The voted bit is 1 when ones > `OVERSAMPLE`/2 (integer division).
  - Both counters clear at the end of each bit period.
- IDLE:
  - When `rx_channel_in`=0 is sampled, go to START. That sample is sample 0 of the start bit.
  - When 1 is sampled, stay in IDLE.
- START:
  - If the start bit votes 0, go to DATA with the bit index cleared.
  - If it votes 1, this is a false start: go to IDLE and produce no output.
- DATA:
  - Shift the voted bit into position `bit_idx`.
  - After bit `BIT_LEN`-1, go to PARITY.
- PARITY: store the voted parity bit, then go to STOP.
- STOP, completion:
  - `parity_err` = XOR of all data bits XOR the parity bit.
  - `frame_err` = NOT (voted stop bit).
  - Complete the frame as described under Holding register.
- STOP, next state:
  - If `frame_err`=0, go to IDLE.
  - If `frame_err`=1, go to WAIT_IDLE.
- WAIT_IDLE: stay until one sample of `rx_channel_in`=1, then go to IDLE. This prevents a stuck-low line from generating frames.
- Holding register:
  - A completed frame loads `rx_data_out`, `rx_parity_err` and `rx_frame_err`, and sets `rx_data_valid`.
  - Frames with errors are still delivered, with their flags set.
  - When `rx_data_valid` and `rx_data_ready` are both high at an edge, the frame is consumed and `rx_data_valid` clears, unless a completion occurs on the same edge.
  - Completion on the same edge as consumption: the new frame loads and `rx_data_valid` stays 1.
  - Completion while `rx_data_valid`=1 and `rx_data_ready`=0: the new frame is discarded, the held contents are unchanged, and `rx_overrun` pulses for one cycle.
- Reset:
  - When `rstn`=0 at an edge, state goes to IDLE and all counters clear.
  - All outputs go to 0, including `rx_data_out`.
  - Reset has priority over every other event. A frame that is in progress when reset asserts is aborted and produces no output.

## Timing
- Let t0 be the edge at which IDLE samples the start bit's first 0.
- Bit k (0 = start) is sampled at edges t0+k·`OVERSAMPLE` through t0+(k+1)·`OVERSAMPLE`−1.
- The last stop sample is at edge t0+(`BIT_LEN`+3)·`OVERSAMPLE`−1, which is t0+29 with the defaults.
- Outputs and `rx_data_valid` are visible after that edge. Latency is 0 extra cycles beyond the frame.
- A new start bit may be sampled on the very next edge after the last stop sample, so back-to-back frames need no idle gap.
- A false start returns to IDLE after `OVERSAMPLE` edges. The next 0 sample restarts detection.
- `rx_overrun` is high for exactly the one cycle after the dropped frame's final stop sample.

## Test plan
- Clean frame, data 1010101, parity 0, stop 1; `rx_data_ready`=0. Required: `rx_data_valid`=1 after t0+29, `rx_data_out`=1010101, both error flags 0, all values held for 20 cycles. Then pulse `rx_data_ready` for 1 cycle: `rx_data_valid`=0 on the next cycle.
- Frame with data 0111010, with the middle sample of every data bit and of the stop bit inverted. Required: `rx_data_out`=0111010 and both error flags 0.
- Data 0000001 with the parity bit sent as 0. Required: `rx_data_out`=0000001, `rx_parity_err`=1, `rx_frame_err`=0.
- Valid data 0000011, then the stop bit low for all 3 samples and the line held low 12 more clocks. Required: `rx_frame_err`=1 and no second frame until the line goes high. A frame started 1 cycle after the line returns high is received correctly.
- Line low for 1 sample, then high. Required: no `rx_data_valid` and the receiver is back in IDLE after 3 cycles. Also assert `rstn`=0 at clock 12 of a clean frame: outputs stay 0 and the following frame is received correctly.
- Two back-to-back frames (1100110, then 0011001) with `rx_data_ready`=0. Required: `rx_overrun` pulses one cycle and `rx_data_out` stays 1100110. Repeat with `rx_data_ready`=1 on the second completion edge: `rx_data_out`=0011001, `rx_data_valid` stays 1, and no overrun.

Source files
------------

// File: rtl/uart_rx_voter_if.sv
// Receive-side bundle for uart_rx_voter: serial line in, one-entry
// valid/ready frame holding register out.
interface uart_rx_voter_if #(
    parameter int unsigned BIT_LEN = 7
);
    logic               rx_channel_in;
    logic               rx_data_ready;
    logic [BIT_LEN-1:0] rx_data_out;
    logic               rx_data_valid;
    logic               rx_parity_err;
    logic               rx_frame_err;
    logic               rx_overrun;

    // Receiver side
    modport master (
        input  rx_channel_in,
        input  rx_data_ready,
        output rx_data_out,
        output rx_data_valid,
        output rx_parity_err,
        output rx_frame_err,
        output rx_overrun
    );

    // Line driver / frame consumer side
    modport slave (
        output rx_channel_in,
        output rx_data_ready,
        input  rx_data_out,
        input  rx_data_valid,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_overrun
    );
endinterface

// File: rtl/uart_rx_voter.sv
// Oversampling UART receiver: majority vote per bit, even parity and stop
// checks, one-entry holding register with overrun pulse.
module uart_rx_voter #(
    parameter int unsigned BIT_LEN    = 7,
    parameter int unsigned OVERSAMPLE = 3
) (
    input  logic            clk,
    input  logic            rstn,
    uart_rx_voter_if.master bus
);
    localparam int unsigned CNT_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned ONES_W = $clog2(OVERSAMPLE + 1);
    localparam int unsigned IDX_W  = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   sample_cnt;
    logic [ONES_W-1:0]  ones_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [BIT_LEN-1:0] data_sr;
    logic               parity_bit;

    logic [ONES_W-1:0]  ones_next_c;
    logic               bit_end_c;
    logic               voted_c;
    logic               parity_err_c;
    logic               frame_err_c;

    // Vote includes the sample taken on the current edge
    always_comb begin
        ones_next_c  = ones_cnt + ONES_W'(bus.rx_channel_in);
        bit_end_c    = (sample_cnt == CNT_W'(OVERSAMPLE - 1));
        voted_c      = (ones_next_c > ONES_W'(OVERSAMPLE / 2));
        parity_err_c = (^data_sr) ^ parity_bit;
        frame_err_c  = ~voted_c;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state             <= IDLE;
            sample_cnt        <= '0;
            ones_cnt          <= '0;
            bit_idx           <= '0;
            data_sr           <= '0;
            parity_bit        <= 1'b0;
            bus.rx_data_out   <= '0;
            bus.rx_data_valid <= 1'b0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_overrun    <= 1'b0;
        end else begin
            bus.rx_overrun <= 1'b0;
            if (bus.rx_data_valid && bus.rx_data_ready) begin
                bus.rx_data_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    // The first low sample is sample 0 of the start bit
                    if (!bus.rx_channel_in) begin
                        state      <= START;
                        sample_cnt <= CNT_W'(1);
                        ones_cnt   <= '0;
                    end
                end
                WAIT_IDLE: begin
                    if (bus.rx_channel_in) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (!bit_end_c) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        ones_cnt   <= ones_next_c;
                    end else begin
                        sample_cnt <= '0;
                        ones_cnt   <= '0;
                        case (state)
                            START: begin
                                if (voted_c) begin
                                    state <= IDLE;
                                end else begin
                                    state   <= DATA;
                                    bit_idx <= '0;
                                end
                            end
                            DATA: begin
                                data_sr[bit_idx] <= voted_c;
                                if (bit_idx == IDX_W'(BIT_LEN - 1)) begin
                                    state <= PARITY;
                                end else begin
                                    bit_idx <= bit_idx + IDX_W'(1);
                                end
                            end
                            PARITY: begin
                                parity_bit <= voted_c;
                                state      <= STOP;
                            end
                            STOP: begin
                                // Load when empty or being drained this edge, else drop
                                if (!bus.rx_data_valid || bus.rx_data_ready) begin
                                    bus.rx_data_out   <= data_sr;
                                    bus.rx_parity_err <= parity_err_c;
                                    bus.rx_frame_err  <= frame_err_c;
                                    bus.rx_data_valid <= 1'b1;
                                end else begin
                                    bus.rx_overrun <= 1'b1;
                                end
                                state <= frame_err_c ? WAIT_IDLE : IDLE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_voter.sv
// Directed bench for uart_rx_voter: frames are driven sample by sample and
// expected frames are queued in a scoreboard, popped when the DUT presents them.
module tb_uart_rx_voter;
    localparam int unsigned BIT_LEN       = 7;
    localparam int unsigned OS            = 3;
    localparam int unsigned FRAME_LEN     = BIT_LEN + 3;
    localparam int          FRAME_SAMPLES = FRAME_LEN * OS;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    uart_rx_voter_if #(.BIT_LEN(BIT_LEN)) bus ();

    uart_rx_voter #(
        .BIT_LEN   (BIT_LEN),
        .OVERSAMPLE(OS)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BIT_LEN-1:0] data;
        logic               perr;
        logic               ferr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic pre_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FRAME_LEN-1:0] mk_frame(input logic [BIT_LEN-1:0] d,
                                                      input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    // Drive samples [first, last) of a frame; inv flips the middle sample of marked bits
    task automatic drive(input logic [FRAME_LEN-1:0] bits, input logic [FRAME_LEN-1:0] inv,
                         input int first, input int last);
        for (int i = first; i < last; i++) begin
            logic b;
            b = bits[i / OS];
            if (inv[i / OS] && ((i % OS) == OS / 2)) b = ~b;
            bus.rx_channel_in = b;
            if (i == FRAME_SAMPLES - 1) pre_valid = bus.rx_data_valid;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [BIT_LEN-1:0] d, input logic par, input logic stop,
                        input logic [FRAME_LEN-1:0] inv);
        drive(mk_frame(d, par, stop), inv, 0, FRAME_SAMPLES);
    endtask

    task automatic push(input logic [BIT_LEN-1:0] d, input logic perr, input logic ferr);
        exp_t e;
        e.data = d;
        e.perr = perr;
        e.ferr = ferr;
        sb.push_back(e);
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        check({tag, ".valid"}, 32'(bus.rx_data_valid), 32'(1));
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s.sb observed=frame expected=empty_queue_entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".data"}, 32'(bus.rx_data_out), 32'(e.data));
            check({tag, ".perr"}, 32'(bus.rx_parity_err), 32'(e.perr));
            check({tag, ".ferr"}, 32'(bus.rx_frame_err), 32'(e.ferr));
        end
    endtask

    task automatic consume(input string tag);
        bus.rx_data_ready = 1'b1;
        @(negedge clk);
        bus.rx_data_ready = 1'b0;
        check({tag, ".consumed"}, 32'(bus.rx_data_valid), 32'(0));
    endtask

    task automatic idle(input int n);
        bus.rx_channel_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 32'(bus.rx_data_valid), 32'(0));
        check({tag, ".data"},  32'(bus.rx_data_out),   32'(0));
        check({tag, ".perr"},  32'(bus.rx_parity_err), 32'(0));
        check({tag, ".ferr"},  32'(bus.rx_frame_err),  32'(0));
        check({tag, ".ovr"},   32'(bus.rx_overrun),    32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_channel_in = 1'b1;
        bus.rx_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        idle(2);

        // Clean frame, held with ready low, then a one-cycle ready pulse
        push(7'b1010101, 1'b0, 1'b0);
        send(7'b1010101, 1'b0, 1'b1, '0);
        bus.rx_channel_in = 1'b1;
        check("t1.latency", 32'(pre_valid), 32'(0));
        check_frame("t1");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("t1.hold_valid", 32'(bus.rx_data_valid), 32'(1));
            check("t1.hold_data",  32'(bus.rx_data_out),   32'(7'b1010101));
        end
        consume("t1");

        // Middle sample of each data bit and of the stop bit inverted
        push(7'b0111010, 1'b0, 1'b0);
        send(7'b0111010, 1'b0, 1'b1, 10'b1_0_1111111_0);
        bus.rx_channel_in = 1'b1;
        check_frame("t2");
        consume("t2");

        // Wrong parity
        push(7'b0000001, 1'b1, 1'b0);
        send(7'b0000001, 1'b0, 1'b1, '0);
        bus.rx_channel_in = 1'b1;
        check_frame("t3");
        consume("t3");

        // Stop bit low, line stuck low 12 more clocks
        push(7'b0000011, 1'b0, 1'b1);
        send(7'b0000011, 1'b0, 1'b0, '0);
        bus.rx_channel_in = 1'b0;
        check_frame("t4");
        consume("t4");
        repeat (11) @(negedge clk);
        check("t4.no_refire", 32'(bus.rx_data_valid), 32'(0));
        idle(1);
        push(7'b1001011, 1'b0, 1'b0);
        send(7'b1001011, 1'b0, 1'b1, '0);
        bus.rx_channel_in = 1'b1;
        check_frame("t4.after");
        consume("t4.after");

        // False start, then a frame right after the 3-cycle recovery
        bus.rx_channel_in = 1'b0;
        @(negedge clk);
        idle(2);
        check("t5.false_start", 32'(bus.rx_data_valid), 32'(0));
        push(7'b0110011, 1'b0, 1'b0);
        send(7'b0110011, 1'b0, 1'b1, '0);
        bus.rx_channel_in = 1'b1;
        check_frame("t5");
        consume("t5");

        // Reset 12 clocks into a frame
        drive(mk_frame(7'b1111000, 1'b0, 1'b1), '0, 0, 12);
        rstn = 1'b0;
        bus.rx_channel_in = 1'b1;
        @(negedge clk);
        check_zero("t5.rst");
        rstn = 1'b1;
        idle(35);
        check_zero("t5.aborted");
        push(7'b1010011, 1'b0, 1'b0);
        send(7'b1010011, 1'b0, 1'b1, '0);
        bus.rx_channel_in = 1'b1;
        check_frame("t5.after_rst");
        consume("t5.after_rst");

        // Back-to-back frames, ready low: second frame dropped with overrun
        push(7'b1100110, 1'b0, 1'b0);
        send(7'b1100110, 1'b0, 1'b1, '0);
        check_frame("t6.a");
        send(7'b0011001, 1'b1, 1'b1, '0);
        bus.rx_channel_in = 1'b1;
        check("t6.ovr_pulse", 32'(bus.rx_overrun),    32'(1));
        check("t6.valid",     32'(bus.rx_data_valid), 32'(1));
        check("t6.data_kept", 32'(bus.rx_data_out),   32'(7'b1100110));
        @(negedge clk);
        check("t6.ovr_end",   32'(bus.rx_overrun),    32'(0));
        check("t6.data_kept2", 32'(bus.rx_data_out),  32'(7'b1100110));
        consume("t6");

        // Back-to-back, ready high on the second completion edge
        push(7'b1100110, 1'b0, 1'b0);
        send(7'b1100110, 1'b0, 1'b1, '0);
        check_frame("t6b.a");
        push(7'b0011001, 1'b0, 1'b0);
        drive(mk_frame(7'b0011001, 1'b1, 1'b1), '0, 0, FRAME_SAMPLES - 1);
        bus.rx_data_ready = 1'b1;
        drive(mk_frame(7'b0011001, 1'b1, 1'b1), '0, FRAME_SAMPLES - 1, FRAME_SAMPLES);
        bus.rx_data_ready = 1'b0;
        bus.rx_channel_in = 1'b1;
        check("t6b.no_ovr", 32'(bus.rx_overrun), 32'(0));
        check_frame("t6b.b");
        consume("t6b");

        check("sb.drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
